serial_uart_bridge: RTL

- Sits between the processor's serial IO port (the byte interface the data memory exposes) and the board UART pins.
- Buffers bytes written by the processor into a TX FIFO and serialises them as 8N1 on uart_txd_out.
- Deserialises uart_rxd_in into an RX FIFO and presents the head byte, a valid flag and a TX-ready flag back to the processor's serial inputs.

---
 rtl/serial_uart_pkg.sv | 20 ++
 rtl/serial_uart_bridge_byte_fifo.sv | 69 ++++++
 rtl/serial_uart_bridge.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_uart_pkg.sv
// Shared types and constants for the serial_uart_bridge slice.
// State encodings, data-width constants and counter-width helper.
package serial_uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int BIT_CNT_W      = $clog2(UART_DATA_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Width needed to count 0 .. clks_per_bit-1
  function automatic int clk_cnt_width(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/serial_uart_bridge_byte_fifo.sv
// First-word fall-through byte FIFO used for both UART directions.
// A push into a full FIFO is accepted when a pop happens that same cycle.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/serial_uart_bridge.sv
// Processor serial-port to 8N1 UART bridge with TX and RX byte FIFOs.
// TX and RX state machines live here; FIFOs are byte_fifo instances.
module serial_uart_bridge
  import serial_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data_in,
  input  logic       tx_wren_in,
  output logic       tx_ready_out,
  input  logic       rx_rden_in,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out,
  output logic       uart_txd_out,
  input  logic       uart_rxd_in
);

  localparam int CNT_W = clk_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(UART_DATA_BITS - 1);

  logic [UART_DATA_BITS-1:0] tx_head;
  logic [UART_DATA_BITS-1:0] rx_head;
  logic tx_empty, tx_full, tx_pop;
  logic rx_empty, rx_full, rx_push;

  uart_state_e               tx_state_q, tx_state_d;
  logic [CNT_W-1:0]          tx_cnt_q, tx_cnt_d;
  logic [BIT_CNT_W-1:0]      tx_bit_q, tx_bit_d;
  logic [UART_DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                      txd_q, txd_d;
  logic                      tx_tick;

  uart_state_e               rx_state_q, rx_state_d;
  logic [CNT_W-1:0]          rx_cnt_q, rx_cnt_d;
  logic [BIT_CNT_W-1:0]      rx_bit_q, rx_bit_d;
  logic [UART_DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                      rx_sync1_q, rx_sync1_d;
  logic                      rx_sync2_q, rx_sync2_d;
  logic                      rx_prev_q, rx_prev_d;
  logic                      overrun_q, overrun_d;
  logic                      frame_err_q, frame_err_d;
  logic                      rx_tick;
  logic                      rx_tick_half;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tx_wren_in),
    .pop   (tx_pop),
    .din   (tx_data_in),
    .dout  (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_rden_in),
    .din   (rx_shift_q),
    .dout  (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

  assign tx_ready_out     = !tx_full;
  assign rx_valid_out     = !rx_empty;
  assign rx_data_out      = rx_head;
  assign rx_overrun_out   = overrun_q;
  assign rx_frame_err_out = frame_err_q;
  assign uart_txd_out     = txd_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    tx_tick    = (tx_cnt_q == CNT_LAST);
    case (tx_state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_tick) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_tick) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_LAST) begin
            txd_d      = 1'b1;
            tx_state_d = ST_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[UART_DATA_BITS-1:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_tick) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when more data waits
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            txd_d      = 1'b0;
            tx_state_d = ST_START;
          end else begin
            tx_state_d = ST_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_sync1_d   = uart_rxd_in;
    rx_sync2_d   = rx_sync1_q;
    rx_prev_d    = rx_sync2_q;
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    overrun_d    = overrun_q;
    frame_err_d  = frame_err_q;
    rx_push      = 1'b0;
    rx_tick      = (rx_cnt_q == CNT_LAST);
    rx_tick_half = (rx_cnt_q == CNT_HALF);
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_sync2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_tick_half) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync2_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[UART_DATA_BITS-1:1]};
          if (rx_bit_q == BIT_LAST) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (rx_tick) begin
          // Leave mid stop bit so the next start edge is never missed
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
          if (!rx_sync2_q) begin
            frame_err_d = 1'b1;
          end else if (rx_full && !rx_rden_in) begin
            overrun_d = 1'b1;
          end else begin
            rx_push = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_sync1_q  <= 1'b1;
      rx_sync2_q  <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= ST_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_sync1_q  <= rx_sync1_d;
      rx_sync2_q  <= rx_sync2_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule
